reg_file_bypass: RTL and testbench
==================================

Name: reg_file_bypass

Overview:
- Parametrised register file: NUM_REGS entries of DATA_W bits, one write port, NUM_RD independent read ports.
- Generation-2 storage array for the CPU decode stage. Storage is per-entry flops with write enable; reads use explicit muxes, with no tri-state bitlines.
- Adds write-to-read bypass, an optional hardwired zero register, and a per-entry "written since reset" valid bit reported on each read port.

Parameters:
- DATA_W, 16, bits per register.
- NUM_REGS, 16, number of entries; power of two, minimum 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG0, 1, 1 = entry 0 reads as zero, ignores writes and always reports valid.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the stored (old) value.
- Derived localparam AW = clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write index.
- wr_data  in  DATA_W  write value.
- rd_addr  in  NUM_RD*AW  packed read indices; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read values; port k occupies bits [k*DATA_W +: DATA_W].
- rd_valid  out  NUM_RD  per-port bit: the addressed entry has been written since reset (or bypass is active).
- clr_valid  in  1  synchronous clear of all valid bits; data is untouched.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries are 0 and all valid bits are 0, immediately.
  - rd_data therefore reads 0 and rd_valid reads 0, except port reading entry 0 when ZERO_REG0=1, which shows valid 1.
- Write:
  - On a rising edge with rst=1 and wr_en=1, entry[wr_addr] <= wr_data and valid[wr_addr] <= 1.
  - Single-cycle write; the value is visible on the stored path the next cycle.
- Read:
  - Combinational, zero latency.
  - rd_data[k] = entry[rd_addr[k]]; rd_valid[k] = valid[rd_addr[k]].
- Bypass (BYPASS=1):
  - Applies when wr_en=1, rst=1 and rd_addr[k]==wr_addr, with the target not being entry 0 under ZERO_REG0.
  - Then rd_data[k]=wr_data and rd_valid[k]=1 in the same cycle.
  - Several ports may bypass at once; each port is evaluated independently.
- BYPASS=0: a same-cycle read of the written entry returns the old contents and old valid bit.
- ZERO_REG0=1:
  - Writes to entry 0 are dropped; valid[0] is not set.
  - Reads of entry 0 return 0 with valid 1, with no bypass.
- clr_valid:
  - On a rising edge, all valid bits are cleared.
  - If wr_en is asserted in the same cycle, the write wins for its own entry: valid[wr_addr]=1 and the rest are 0.
  - Combinational bypass in that cycle is unaffected.
- Reset mid-write: asynchronous reset dominates; the entry stays 0 and valid stays 0.
- Out-of-range address: impossible, because NUM_REGS is a power of two.
- There are no X outputs after reset under any input combination.

Decomposition:
- Shared package (rf_pkg): default DATA_W/NUM_REGS constants and a clog2 function.
- Natural sub-module: rf_entry, one DATA_W register with write enable, async active-low reset and a valid flop. It is instantiated NUM_REGS times with a generate loop.
- Read muxing and bypass logic live in the top module, one generate iteration per read port.

Test Plan (defaults unless noted):
- Reset, then hold: rst low, addrs 0/5 -> rd_data 0/0, rd_valid 1/0 while low and after release with no writes.
- Write then read: write entry 3 = 0xBEEF; next cycle rd_addr0=3 -> rd_data0 0xBEEF, rd_valid0 1; rd_addr1=4 -> 0x0000, valid 0.
- Bypass on both ports: wr_en=1, wr_addr=7, wr_data=0x1234, rd_addr0=rd_addr1=7, same cycle -> both ports 0x1234 valid 1. Repeat with BYPASS=0 -> both ports show old value and old valid.
- Zero register: write entry 0 = 0xFFFF, with a read of entry 0 in that cycle and the next -> rd_data 0, valid 1 both cycles. Repeat with ZERO_REG0=0 -> 0xFFFF next cycle.
- clr_valid with write: entries 2 and 9 written, then clr_valid=1 with a write of entry 9 = 0x0042 -> next cycle entry 2 valid 0 (data retained), entry 9 = 0x0042 valid 1.
- Async reset mid-operation: assert rst between clock edges while wr_en=1 -> outputs go to 0/valid 0 before the next edge; no write lands after release until wr_en is reasserted.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the decode-stage register file.
//   DEFAULT_DATA_W / DEFAULT_NUM_REGS / DEFAULT_NUM_RD : default geometry
//   rd_src_e : where a read port takes its value from this cycle
//   clog2()  : elaboration-time ceiling log2, used to size the index busses
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 16;
    localparam int DEFAULT_NUM_RD   = 2;

    // Read-port source selection. ZERO outranks BYPASS so that a write
    // aimed at the hardwired zero entry can never leak onto a read port.
    typedef enum logic [1:0] {
        RD_SRC_STORED = 2'd0,
        RD_SRC_BYPASS = 2'd1,
        RD_SRC_ZERO   = 2'd2
    } rd_src_e;

    // Smallest r with (1 << r) >= value. Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_entry.sv
// ---------------------------------------------------------------------------
// rf_entry
// One register-file entry: a DATA_W data register plus a "written since
// reset" valid flop.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (data and valid both go to 0)
//   we    : write enable for this entry (already address-decoded)
//   d     : write data
//   clr   : synchronous clear of the valid flop; data is kept
//   q     : stored data
//   valid : entry has been written since reset / last clear
// ---------------------------------------------------------------------------
module rf_entry #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    input  logic              clr,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (we) begin
                data_reg <= d;
            end
            // A write in the same cycle as a clear keeps this entry valid.
            if (we) begin
                valid_reg <= 1'b1;
            end else if (clr) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign q     = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/reg_file_bypass.sv
// ---------------------------------------------------------------------------
// reg_file_bypass
// NUM_REGS x DATA_W register file, one write port, NUM_RD combinational read
// ports, optional write-to-read bypass and optional hardwired zero entry.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   wr_en     : write strobe
//   wr_addr   : write index
//   wr_data   : write value
//   rd_addr   : packed read indices, port k at [k*AW +: AW]
//   rd_data   : packed read values, port k at [k*DATA_W +: DATA_W]
//   rd_valid  : per port, addressed entry written since reset (or bypassed)
//   clr_valid : synchronous clear of every valid bit (data retained)
// ---------------------------------------------------------------------------
module reg_file_bypass
    import rf_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int NUM_RD    = DEFAULT_NUM_RD,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clr_valid
);

    logic [DATA_W-1:0]   entry_q [NUM_REGS];
    logic [NUM_REGS-1:0] entry_v;

    // -----------------------------------------------------------------------
    // Storage. Entry 0 collapses to constants when it is the zero register:
    // it reads 0 and reports valid even while reset is held.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if ((ZERO_REG0 != 0) && (gi == 0)) begin : g_zero
                assign entry_q[gi] = '0;
                assign entry_v[gi] = 1'b1;
            end else begin : g_reg
                logic we;
                assign we = wr_en && (wr_addr == AW'(gi));

                rf_entry #(
                    .DATA_W (DATA_W)
                ) u_entry (
                    .clk   (clk),
                    .rst   (rst),
                    .we    (we),
                    .d     (wr_data),
                    .clr   (clr_valid),
                    .q     (entry_q[gi]),
                    .valid (entry_v[gi])
                );
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read ports: independent mux + bypass per port.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]     addr;
            rd_src_e           src;
            logic [DATA_W-1:0] data_next;
            logic              valid_next;

            assign addr = rd_addr[gi*AW +: AW];

            // Bypass is qualified with rst so that asserting reset between
            // edges forces the outputs to the reset state immediately, even
            // if wr_en is still high.
            always_comb begin
                src = RD_SRC_STORED;
                if ((ZERO_REG0 != 0) && (addr == '0)) begin
                    src = RD_SRC_ZERO;
                end else if ((BYPASS != 0) && wr_en && rst && (addr == wr_addr)) begin
                    src = RD_SRC_BYPASS;
                end
            end

            always_comb begin
                data_next  = entry_q[addr];
                valid_next = entry_v[addr];
                case (src)
                    RD_SRC_ZERO: begin
                        data_next  = '0;
                        valid_next = 1'b1;
                    end
                    RD_SRC_BYPASS: begin
                        data_next  = wr_data;
                        valid_next = 1'b1;
                    end
                    default: begin
                        data_next  = entry_q[addr];
                        valid_next = entry_v[addr];
                    end
                endcase
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data_next;
            assign rd_valid[gi]                 = valid_next;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_bypass.sv
// ---------------------------------------------------------------------------
// tb_reg_file_bypass
// Two instances share all inputs: dut_a uses the defaults (bypass on, zero
// register on), dut_b has both features off. Directed table vectors with
// hand-computed expectations, hand-written reset sequences, then random
// traffic compared against an array-based model of the register file.
// ---------------------------------------------------------------------------
module tb_reg_file_bypass;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int RD = 2;

    logic           clk;
    logic           rst;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [RD*AW-1:0] rd_addr;
    logic           clr_valid;
    logic [RD*DW-1:0] rd_data_a, rd_data_b;
    logic [RD-1:0]  rd_valid_a, rd_valid_b;

    int checks   = 0;
    int failures = 0;

    reg_file_bypass #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .ZERO_REG0(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .clr_valid(clr_valid)
    );

    reg_file_bypass #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .ZERO_REG0(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .clr_valid(clr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Index 0 = config A (zero reg + bypass), 1 = config B (neither).
    logic [DW-1:0] mem [2][NR];
    bit            vld [2][NR];
    bit            cfg_zero [2] = '{1'b1, 1'b0};
    bit            cfg_byp  [2] = '{1'b1, 1'b0};

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < NR; i++) begin
                mem[c][i] = '0;
                vld[c][i] = 1'b0;
            end
    endtask

    // What one rising edge does to the architectural state.
    task automatic model_edge();
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                if (clr_valid)
                    for (int i = 0; i < NR; i++) vld[c][i] = 1'b0;
                if (wr_en && !(cfg_zero[c] && wr_addr == 0)) begin
                    mem[c][wr_addr] = wr_data;
                    vld[c][wr_addr] = 1'b1;
                end
            end
        end
    endtask

    function automatic void model_read(input int c, input logic [AW-1:0] a,
                                       output logic [DW-1:0] d, output logic v);
        if (cfg_zero[c] && a == 0) begin
            d = '0; v = 1'b1;
        end else if (cfg_byp[c] && rst && wr_en && a == wr_addr) begin
            d = wr_data; v = 1'b1;
        end else begin
            d = mem[c][a]; v = vld[c][a];
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] act_data(input int c, input int k);
        return (c == 0) ? rd_data_a[k*DW +: DW] : rd_data_b[k*DW +: DW];
    endfunction

    function automatic logic act_valid(input int c, input int k);
        return (c == 0) ? rd_valid_a[k] : rd_valid_b[k];
    endfunction

    task automatic check_model(input string tag);
        logic [DW-1:0] d;
        logic          v;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < RD; k++) begin
                model_read(c, rd_addr[k*AW +: AW], d, v);
                chk($sformatf("%s cfg%0d p%0d data", tag, c, k), act_data(c, k), d);
                chk($sformatf("%s cfg%0d p%0d valid", tag, c, k), {15'd0, act_valid(c, k)}, {15'd0, v});
            end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          clr;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] ad0; logic av0; logic [DW-1:0] ad1; logic av1;
        logic [DW-1:0] bd0; logic bv0; logic [DW-1:0] bd1; logic bv1;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Expectations are sampled before the edge that performs the write.
        //          we wa  wd       clr ra0 ra1 | A: d0  v0 d1  v1 | B: d0 v0 d1 v1
        vecs[0]  = '{0, 0, 16'h0000, 0, 0, 5, 16'h0000,1, 16'h0000,0, 16'h0000,0, 16'h0000,0};
        vecs[1]  = '{1, 3, 16'hBEEF, 0, 3, 4, 16'hBEEF,1, 16'h0000,0, 16'h0000,0, 16'h0000,0};
        vecs[2]  = '{0, 0, 16'h0000, 0, 3, 4, 16'hBEEF,1, 16'h0000,0, 16'hBEEF,1, 16'h0000,0};
        vecs[3]  = '{1, 7, 16'h1234, 0, 7, 7, 16'h1234,1, 16'h1234,1, 16'h0000,0, 16'h0000,0};
        vecs[4]  = '{1, 7, 16'h5678, 0, 7, 7, 16'h5678,1, 16'h5678,1, 16'h1234,1, 16'h1234,1};
        vecs[5]  = '{0, 0, 16'h0000, 0, 7, 3, 16'h5678,1, 16'hBEEF,1, 16'h5678,1, 16'hBEEF,1};
        vecs[6]  = '{1, 0, 16'hFFFF, 0, 0, 0, 16'h0000,1, 16'h0000,1, 16'h0000,0, 16'h0000,0};
        vecs[7]  = '{0, 0, 16'h0000, 0, 0, 7, 16'h0000,1, 16'h5678,1, 16'hFFFF,1, 16'h5678,1};
        vecs[8]  = '{1, 2, 16'h00AA, 0, 2, 9, 16'h00AA,1, 16'h0000,0, 16'h0000,0, 16'h0000,0};
        vecs[9]  = '{1, 9, 16'h0099, 0, 9, 2, 16'h0099,1, 16'h00AA,1, 16'h0000,0, 16'h00AA,1};
        vecs[10] = '{1, 9, 16'h0042, 1, 9, 2, 16'h0042,1, 16'h00AA,1, 16'h0099,1, 16'h00AA,1};
        vecs[11] = '{0, 0, 16'h0000, 0, 2, 9, 16'h00AA,0, 16'h0042,1, 16'h00AA,0, 16'h0042,1};
        vecs[12] = '{0, 0, 16'h0000, 0, 0, 3, 16'h0000,1, 16'hBEEF,0, 16'hFFFF,0, 16'hBEEF,0};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = {4'd5, 4'd0};
        clr_valid = 1'b0;
        model_reset();

        // Reset held: entry 0 valid only on the zero-register instance.
        #1;
        chk("rst_hold A p0 data",  act_data(0, 0), 16'h0000);
        chk("rst_hold A p0 valid", {15'd0, act_valid(0, 0)}, 16'h0001);
        chk("rst_hold A p1 data",  act_data(0, 1), 16'h0000);
        chk("rst_hold A p1 valid", {15'd0, act_valid(0, 1)}, 16'h0000);
        chk("rst_hold B p0 valid", {15'd0, act_valid(1, 0)}, 16'h0000);
        $display("reset held: rd0=%h/%b rd1=%h/%b", act_data(0,0), act_valid(0,0), act_data(0,1), act_valid(0,1));
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            wr_en     = vecs[i].we;
            wr_addr   = vecs[i].wa;
            wr_data   = vecs[i].wd;
            clr_valid = vecs[i].clr;
            rd_addr   = {vecs[i].ra1, vecs[i].ra0};
            #3;
            chk($sformatf("vec%0d A p0 data", i),  act_data(0, 0), vecs[i].ad0);
            chk($sformatf("vec%0d A p0 valid", i), {15'd0, act_valid(0, 0)}, {15'd0, vecs[i].av0});
            chk($sformatf("vec%0d A p1 data", i),  act_data(0, 1), vecs[i].ad1);
            chk($sformatf("vec%0d A p1 valid", i), {15'd0, act_valid(0, 1)}, {15'd0, vecs[i].av1});
            chk($sformatf("vec%0d B p0 data", i),  act_data(1, 0), vecs[i].bd0);
            chk($sformatf("vec%0d B p0 valid", i), {15'd0, act_valid(1, 0)}, {15'd0, vecs[i].bv0});
            chk($sformatf("vec%0d B p1 data", i),  act_data(1, 1), vecs[i].bd1);
            chk($sformatf("vec%0d B p1 valid", i), {15'd0, act_valid(1, 1)}, {15'd0, vecs[i].bv1});
            $display("vec %0d: we=%b wa=%0d wd=%h clr=%b ra=%0d/%0d A=%h/%b %h/%b B=%h/%b %h/%b",
                     i, wr_en, wr_addr, wr_data, clr_valid, vecs[i].ra0, vecs[i].ra1,
                     act_data(0,0), act_valid(0,0), act_data(0,1), act_valid(0,1),
                     act_data(1,0), act_valid(1,0), act_data(1,1), act_valid(1,1));
            @(posedge clk);
            model_edge();
            #1;
        end

        // Async reset mid-write: land 5=5555, then drop rst between edges
        // while a write of 5 is pending.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555; clr_valid = 1'b0;
        rd_addr = {4'd0, 4'd5};
        @(posedge clk); model_edge(); #1;
        wr_data = 16'hAAAA;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_model("arst_mid");
        $display("async reset mid-write: A rd5=%h/%b B rd5=%h/%b", act_data(0,0), act_valid(0,0), act_data(1,0), act_valid(1,0));
        @(posedge clk); #1;
        check_model("arst_edge_held");
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_model("arst_release");
        @(posedge clk); model_edge(); #1;
        check_model("arst_no_write");
        $display("after reset release, no write: A rd5=%h/%b B rd5=%h/%b", act_data(0,0), act_valid(0,0), act_data(1,0), act_valid(1,0));
        wr_en = 1'b1; wr_data = 16'h0707;
        #3; check_model("arst_rewrite_byp");
        @(posedge clk); model_edge(); #1;
        wr_en = 1'b0;
        #3; check_model("arst_rewrite_stored");
        $display("rewrite after reset: A rd5=%h/%b B rd5=%h/%b", act_data(0,0), act_valid(0,0), act_data(1,0), act_valid(1,0));
        @(posedge clk); model_edge(); #1;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = AW'($urandom_range(0, NR-1));
            wr_data   = DW'($urandom);
            clr_valid = ($urandom_range(0, 15) == 0);
            // Bias reads toward the written entry to exercise bypass often.
            rd_addr[0 +: AW]  = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NR-1));
            rd_addr[AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NR-1));
            #3;
            check_model($sformatf("rand%0d", n));
            $display("rand %0d: we=%b wa=%0d wd=%h clr=%b ra=%0d/%0d A=%h/%b %h/%b B=%h/%b %h/%b",
                     n, wr_en, wr_addr, wr_data, clr_valid, rd_addr[0 +: AW], rd_addr[AW +: AW],
                     act_data(0,0), act_valid(0,0), act_data(0,1), act_valid(0,1),
                     act_data(1,0), act_valid(1,0), act_data(1,1), act_valid(1,1));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
